// File: rtl/of_convert.sv
// Local stream to AXI4-Stream master: frames beats with tuser/tlast, buffers them in a
// FIFO with a first-word-fall-through output register, and flags framing/overflow errors.
module of_convert #(
    parameter int IMG_W      = 2048,
    parameter int IMG_H      = 2048,
    parameter int FIFO_DEPTH = 512,
    parameter int AFULL_LVL  = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] din,
    input  logic        din_vld,
    input  logic        frame_start,
    input  logic [1:0]  frame_type_i,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [1:0]  frame_type_o,
    output logic        fifo_afull,
    output logic        overflow,
    output logic        unexpected_data,
    output logic        short_frame
);
    localparam int LINE_BEATS = IMG_W / 8;
    localparam int BW = $clog2(LINE_BEATS + 1);
    localparam int HW = $clog2(IMG_H + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] LB_LAST = BW'(LINE_BEATS - 1);
    localparam logic [HW-1:0] LN_LAST = HW'(IMG_H - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state_reg, state_next;
    logic [BW-1:0] beat_reg, beat_next, eff_beat;
    logic [HW-1:0] line_reg, line_next, eff_line;
    logic          first_reg, first_next, eff_first;
    logic [1:0]    ftype_reg, ftype_next;
    logic          is_final, restart, take, sof, eol, last_beat;
    logic          short_next, unexp_next;

    // Framing: a frame_start either restarts the counters, or (when it coincides with the
    // final beat) lets that beat close the old frame and arms the next beat as beat 0.
    always_comb begin
        is_final   = (beat_reg == LB_LAST) && (line_reg == LN_LAST);
        restart    = frame_start && !((state_reg == ACTIVE) && din_vld && is_final);
        eff_beat   = restart ? '0 : beat_reg;
        eff_line   = restart ? '0 : line_reg;
        eff_first  = restart ? 1'b1 : first_reg;
        take       = din_vld && ((state_reg == ACTIVE) || frame_start);
        sof        = eff_first;
        eol        = (eff_beat == LB_LAST);
        last_beat  = eol && (eff_line == LN_LAST);

        state_next = ((state_reg == ACTIVE) || frame_start) ? ACTIVE : IDLE;
        beat_next  = eff_beat;
        line_next  = eff_line;
        first_next = eff_first;
        ftype_next = frame_start ? frame_type_i : ftype_reg;

        if (take) begin
            first_next = 1'b0;
            if (eol) begin
                beat_next = '0;
                if (last_beat) begin
                    line_next = '0;
                    if (frame_start && !restart) begin
                        first_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    line_next = eff_line + 1'b1;
                end
            end else begin
                beat_next = eff_beat + 1'b1;
            end
        end

        short_next = (state_reg == ACTIVE) && frame_start && !first_reg && !(din_vld && is_final);
        unexp_next = (state_reg == IDLE) && !frame_start && din_vld;
    end

    // FIFO storage; the output register doubles as the registered RAM read port.
    logic [65:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   cnt_reg, cnt_next, level, level_next;
    logic          out_vld_next, hs, wr_ok, wr, drop, pop;

    always_comb begin
        hs           = m_axis_tvalid && m_axis_tready;
        level        = cnt_reg + (AW+1)'(m_axis_tvalid);
        wr_ok        = (level < (AW+1)'(FIFO_DEPTH)) || hs;
        wr           = take && wr_ok;
        drop         = take && !wr_ok;
        pop          = (cnt_reg != '0) && (!m_axis_tvalid || m_axis_tready);
        cnt_next     = cnt_reg + (AW+1)'(wr) - (AW+1)'(pop);
        out_vld_next = pop ? 1'b1 : (hs ? 1'b0 : m_axis_tvalid);
        level_next   = cnt_next + (AW+1)'(out_vld_next);
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr_reg] <= {sof, eol, din};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (pop) begin
            {m_axis_tuser, m_axis_tlast, m_axis_tdata} <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            beat_reg        <= '0;
            line_reg        <= '0;
            first_reg       <= 1'b0;
            ftype_reg       <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            cnt_reg         <= '0;
            m_axis_tvalid   <= 1'b0;
            fifo_afull      <= 1'b0;
            overflow        <= 1'b0;
            unexpected_data <= 1'b0;
            short_frame     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            beat_reg        <= beat_next;
            line_reg        <= line_next;
            first_reg       <= first_next;
            ftype_reg       <= ftype_next;
            wr_ptr_reg      <= wr ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
            rd_ptr_reg      <= pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
            cnt_reg         <= cnt_next;
            m_axis_tvalid   <= out_vld_next;
            fifo_afull      <= (level_next >= (AW+1)'(AFULL_LVL));
            overflow        <= drop;
            unexpected_data <= unexp_next;
            short_frame     <= short_next;
        end
    end

    assign frame_type_o = ftype_reg;
endmodule
